// File: rtl/hamming_engine.sv
// hamming_engine: SECDED Hamming(16,11) codec engine acting as a byte-wide
// data-memory master. Walks NMSG two-byte messages from SRC_BASE, encodes
// (mode 0) or corrects/flags (mode 1) each one and writes the results to
// DST_BASE, then raises done.
//
// Optional feature macro: HAMMING_ERR_CNT_EN
//   defined   -> saturating single/double error counters (decode mode only)
//   undefined -> sec_cnt/ded_cnt tied to zero, no counter logic
//
// state  | meaning
// IDLE   | waiting for start; done holds the result of the last run
// RD_LO  | source lo address on the bus
// RD_HI  | source hi address on the bus, lo byte arrives
// CAP    | hi byte arrives, codec result computed
// WR_LO  | lo result written to destination
// WR_HI  | hi result written, advance to next message or finish

module hamming_engine #(
  parameter int NMSG     = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int AW       = 8,
  parameter int CNTW     = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  output logic            done,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [7:0]      mem_wdata,
  input  logic [7:0]      mem_rdata,
  output logic [CNTW-1:0] sec_cnt,
  output logic [CNTW-1:0] ded_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    CAP   = 3'd3,
    WR_LO = 3'd4,
    WR_HI = 3'd5
  } state_t;

  localparam logic [AW-1:0] SRC_A = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_A = AW'(DST_BASE);
  localparam logic [6:0]    LAST  = 7'(NMSG - 1);

  state_t     state;
  logic [6:0] idx;
  logic       mode_q;
  logic [7:0] lo_q;
  logic [7:0] res_hi_q;

  logic [AW-1:0] off_cur;
  logic [AW-1:0] off_nxt;

  assign off_cur = AW'({idx, 1'b0});
  assign off_nxt = AW'({idx + 7'd1, 1'b0});

  logic [15:0] raw;
  logic [15:0] cw_d;
  logic [15:0] enc;
  logic [3:0]  syn;
  logic        q;
  logic [15:0] fix;
  logic [1:0]  flag;
  logic [7:0]  res_lo;
  logic [7:0]  res_hi;

  // Codec datapath: raw word is the captured lo byte plus the hi byte on the bus
  always_comb begin
    raw  = {mem_rdata, lo_q};
    // place d11..d1 at their codeword positions, parity slots zero
    cw_d = {raw[10:4], 1'b0, raw[3:1], 1'b0, raw[0], 3'b000};
    enc  = cw_d | {7'b0, ^(cw_d & 16'hFF00), 3'b0, ^(cw_d & 16'hF0F0),
                   1'b0, ^(cw_d & 16'hCCCC), ^(cw_d & 16'hAAAA), 1'b0};
    enc[0] = ^enc[15:1];

    syn  = {^(raw & 16'hFF00), ^(raw & 16'hF0F0),
            ^(raw & 16'hCCCC), ^(raw & 16'hAAAA)};
    q    = ^raw;
    fix  = raw;
    flag = 2'b00;
    if (q) begin
      fix  = raw ^ (16'd1 << syn);
      flag = 2'b01;
    end else if (syn != 4'd0) begin
      flag = 2'b10;
    end

    if (mode_q) begin
      res_hi = {flag, 3'b000, fix[15:13]};
      res_lo = {fix[12:9], fix[7:5], fix[3]};
    end else begin
      res_hi = enc[15:8];
      res_lo = enc[7:0];
    end
  end

  // Sequencer: walks the messages and drives the registered memory bus
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      idx       <= 7'd0;
      mode_q    <= 1'b0;
      lo_q      <= 8'd0;
      res_hi_q  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (start) begin
            state    <= RD_LO;
            idx      <= 7'd0;
            done     <= 1'b0;
            mode_q   <= mode;
            mem_addr <= SRC_A;
          end
        end
        RD_LO: begin
          mem_addr <= SRC_A + off_cur + AW'(1);
          state    <= RD_HI;
        end
        RD_HI: begin
          lo_q  <= mem_rdata;
          state <= CAP;
        end
        CAP: begin
          res_hi_q  <= res_hi;
          mem_wdata <= res_lo;
          mem_we    <= 1'b1;
          mem_addr  <= DST_A + off_cur;
          state     <= WR_LO;
        end
        WR_LO: begin
          mem_wdata <= res_hi_q;
          mem_addr  <= DST_A + off_cur + AW'(1);
          state     <= WR_HI;
        end
        WR_HI: begin
          mem_we <= 1'b0;
          if (idx == LAST) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            idx      <= idx + 7'd1;
            mem_addr <= SRC_A + off_nxt;
            state    <= RD_LO;
          end
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAMMING_ERR_CNT_EN
  localparam logic [CNTW-1:0] CMAX = {CNTW{1'b1}};

  // Error counters: the flag rides in the top bits of the decoded hi byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (state == IDLE && start) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (state == WR_HI && mode_q) begin
      if (res_hi_q[7:6] == 2'b01 && sec_cnt != CMAX) sec_cnt <= sec_cnt + 1'b1;
      if (res_hi_q[7:6] == 2'b10 && ded_cnt != CMAX) ded_cnt <= ded_cnt + 1'b1;
    end
  end
`else
  assign sec_cnt = '0;
  assign ded_cnt = '0;
`endif

endmodule

// File: doc/hamming_engine.md
# hamming_engine

Hardware SECDED Hamming(16,11) codec engine that replaces the software encode/decode programs. After a `start` pulse it walks `NMSG` messages in byte-wide data memory, encoding (mode 0) or correcting/flagging (mode 1) each one, and writes the results to a destination region. It then raises `done`. It sits beside the core as a data-memory master and uses the same byte layout and `start`/`done` handshake as the course programs.

## Interface
- `NMSG`, 15: messages per run (1..127).
- `SRC_BASE`, 0: byte address of the first source message.
- `DST_BASE`, 30: byte address of the first destination message.
- `AW`, 8: memory address width.
- `CNTW`, 8: width of the error counters.

Ports:
- `clk`  in  1  clock (one clock domain); all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  run request, sampled only in IDLE.
- `mode`  in  1  0 = encode, 1 = decode; latched when `start` is accepted.
- `done`  out  1  run complete; held high until the next accepted `start`.
- `mem_addr`  out  AW  memory byte address.
- `mem_we`  out  1  memory write strobe.
- `mem_wdata`  out  8  memory write data.
- `mem_rdata`  in  8  memory read data; valid one cycle after the address.
- `sec_cnt`  out  CNTW  number of single errors corrected (see Configuration).
- `ded_cnt`  out  CNTW  number of double errors detected (see Configuration).

## Operation
- Message `i` uses lo byte address `BASE+2i` and hi byte address `BASE+2i+1`. All addresses wrap modulo 2^AW.
- Codeword bit map, b[15:0]:
  - b15..b9 = d11..d5
  - b8 = p8
  - b7..b5 = d4..d2
  - b4 = p4
  - b3 = d1
  - b2 = p2
  - b1 = p1
  - b0 = p0
- Encode:
  - Source hi byte bits [2:0] = d11..d9; bits [7:3] are ignored. Source lo byte = d8..d1.
  - p1, p2, p4, p8 are each the XOR of b[j] for j in 1..15 with the corresponding index bit set (1, 2, 4, 8).
  - p0 is the XOR of b15..b1.
  - Output hi byte = b15..b8, lo byte = b7..b0.
- Decode:
  - Syndrome s[3:0]: bit k is the XOR of b[j] for j in 1..15 with index bit k set.
  - Overall check q is the XOR of b15..b0.
  - q=0, s=0: F=00, data unchanged.
  - q=1: single error; b[s] is flipped (s=0 means p0), F=01.
  - q=0, s≠0: double error; F=10, data output uncorrected.
  - Output hi byte = {F[1:0], 3'b000, d11..d9}; output lo byte = d8..d1.
- FSM states and transitions:
  - IDLE: `start`=1 → RD_LO, with idx=0, `done`←0, `mode` latched, counters cleared.
  - RD_LO: `mem_addr` = SRC lo address → RD_HI.
  - RD_HI: `mem_addr` = SRC hi address; lo byte captured → CAP.
  - CAP: hi byte captured → WR_LO.
  - WR_LO: `mem_we`=1, lo result written → WR_HI.
  - WR_HI: `mem_we`=1, hi result written, counters updated. If idx==NMSG-1 → IDLE with `done`←1; otherwise idx++ and → RD_LO.
- `start` is ignored outside IDLE. `mode` changes during a run have no effect.
- `mem_we` is 0 in every state except WR_LO and WR_HI.

## Timing
- Reset (asynchronous, immediate) values:
  - state = IDLE
  - `done` = 0
  - `mem_we` = 0
  - `mem_addr` = 0
  - `mem_wdata` = 0
  - idx = 0
  - `sec_cnt` = 0, `ded_cnt` = 0
- Each message takes 5 cycles.
- With `start` sampled at rising edge E0, `done` is high after edge E(5·NMSG). For NMSG=15 this is E75.
- A `start` sampled in the same cycle that `done` is high begins a new run and clears `done` at that edge.
- Reset during a run abandons it. Bytes already written stay in memory. No further writes occur after reset asserts.

## Configuration
- `HAMMING_ERR_CNT_EN` defined:
  - `sec_cnt` increments on each F=01 result and `ded_cnt` on each F=10 result, in decode mode only.
  - Both counters saturate at 2^CNTW−1 and are cleared when `start` is accepted.
- `HAMMING_ERR_CNT_EN` undefined: `sec_cnt` and `ded_cnt` are tied to 0 and no counter logic is built.

## Test plan
- Encode 11'h000, 11'h7FF and 11'h001 (NMSG=3) → destination hi/lo bytes 00/00, FF/FF and 00/0F. `done` high after E15.
- Decode codeword 0xFDFF (bit 9 flipped from 0xFFFF) → hi 0x47, lo 0xFF. `sec_cnt`=1 when the macro is defined.
- Decode 0xFDF7 (bits 9 and 3 flipped) → hi 0x87, lo 0xEE. `ded_cnt`=1 when the macro is defined.
- Decode 0xFFFE (p0 flipped) → hi 0x47, lo 0xFF. Decode 0xFFFF → hi 0x07, lo 0xFF.
- 15 random messages: encode, flip random bits in the encoded region, then decode → original data recovered with correct F flags. Address bus shows the exact sequence SRC+2i, SRC+2i+1, DST+2i, DST+2i+1. `done` at E75.
- Robustness:
  - Pulse `start` mid-run → ignored.
  - Assert `reset` at cycle 20 → `done`=0 and `mem_we`=0 immediately, state IDLE.
  - A subsequent `start` completes a clean run.
